tts_sym_xlate: RTL and testbench



---
 rtl/tts_sym_xlate_if.sv | 45 ++++
 rtl/tts_sym_xlate.sv | 170 +++++++++++++++++
 tb/tb_tts_sym_xlate.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tts_sym_xlate_if.sv
// Lookup/response/host-write bundle for tts_sym_xlate.
//   slave  : the translator (takes requests and host writes, drives responses)
//   master : the requester/host side
// Request : req_valid, req_ready, req_sym, req_tag
// Response: rsp_valid, rsp_ready, rsp_idx, rsp_hit, rsp_tag
// Host    : hw_en, hw_addr, hw_slot, hw_vld, hw_idx
interface tts_sym_xlate_if #(
  parameter int unsigned SYM_ID_WIDTH   = 16,
  parameter int unsigned IDX_WIDTH      = 14,
  parameter int unsigned SLOTS_PER_WORD = 4,
  parameter int unsigned TAG_WIDTH      = 8
);
  localparam int unsigned SEL_BITS = $clog2(SLOTS_PER_WORD);
  localparam int unsigned SEL_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int unsigned ADDR_W   = SYM_ID_WIDTH - SEL_BITS;

  logic                    req_valid;
  logic                    req_ready;
  logic [SYM_ID_WIDTH-1:0] req_sym;
  logic [TAG_WIDTH-1:0]    req_tag;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDX_WIDTH-1:0]    rsp_idx;
  logic                    rsp_hit;
  logic [TAG_WIDTH-1:0]    rsp_tag;

  logic                    hw_en;
  logic [ADDR_W-1:0]       hw_addr;
  logic [SEL_W-1:0]        hw_slot;
  logic                    hw_vld;
  logic [IDX_WIDTH-1:0]    hw_idx;

  modport slave (
    input  req_valid, req_sym, req_tag, rsp_ready,
    input  hw_en, hw_addr, hw_slot, hw_vld, hw_idx,
    output req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_tag
  );

  modport master (
    output req_valid, req_sym, req_tag, rsp_ready,
    output hw_en, hw_addr, hw_slot, hw_vld, hw_idx,
    input  req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_tag
  );
endinterface

// File: rtl/tts_sym_xlate.sv
// Pipelined symbol-ID to book-index translator.
// A packed table (SLOTS_PER_WORD slots of {valid, index} per word) is read on
// request accept; slot select and tag ride a RAM_LATENCY-deep shift register
// alongside the read, the slot is muxed out, and {hit, idx, tag} goes into a
// credit-protected output FIFO.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : request / response / host slot-write bundle (slave side)
//   miss_cnt     : saturating count of miss lookups
//   inflight     : outstanding credits (accepted, not yet returned or dropped)
module tts_sym_xlate #(
  parameter int unsigned SYM_ID_WIDTH   = 16,
  parameter int unsigned IDX_WIDTH      = 14,
  parameter int unsigned SLOTS_PER_WORD = 4,
  parameter int unsigned RAM_LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter bit          DROP_MISS      = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  tts_sym_xlate_if.slave                bus,
  output logic [31:0]                   miss_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   inflight
);

  localparam int unsigned SLOT_W   = IDX_WIDTH + 1;
  localparam int unsigned WORD_W   = SLOTS_PER_WORD * SLOT_W;
  localparam int unsigned SEL_BITS = $clog2(SLOTS_PER_WORD);
  localparam int unsigned SEL_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int unsigned ADDR_W   = SYM_ID_WIDTH - SEL_BITS;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned ENTRY_W  = 1 + IDX_WIDTH + TAG_WIDTH;
  localparam int unsigned LAST     = RAM_LATENCY - 1;

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic [ADDR_W-1:0] req_addr;
  logic [SEL_W-1:0]  req_sel;
  logic [SEL_W-1:0]  wr_slot;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  assign bus.req_ready = (inflight_q < CntFull);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_addr      = bus.req_sym[SYM_ID_WIDTH-1 -: ADDR_W];
  // With a single slot per word every symbol bit is address; select is 0.
  assign req_sel       = (SEL_BITS > 0) ? bus.req_sym[SEL_W-1:0] : '0;
  assign wr_slot       = (SEL_BITS > 0) ? bus.hw_slot : '0;

  // ---------------------------------------------------------------------------
  // Table RAM and data pipeline (no reset: table survives reset, data is
  // qualified by vld_q)
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]    mem    [2**ADDR_W];
  logic [WORD_W-1:0]    word_q [RAM_LATENCY];
  logic [SEL_W-1:0]     sel_q  [RAM_LATENCY];
  logic [TAG_WIDTH-1:0] tag_q  [RAM_LATENCY];
  logic [RAM_LATENCY-1:0] vld_q;

  always_ff @(posedge clk) begin
    // Slot write-enable: only the addressed slot's bits are written. The read
    // below uses the pre-write contents on a same-cycle collision.
    for (int k = 0; k < int'(SLOTS_PER_WORD); k++) begin
      if (bus.hw_en && (int'(wr_slot) == k)) begin
        mem[bus.hw_addr][k*SLOT_W +: SLOT_W] <= {bus.hw_vld, bus.hw_idx};
      end
    end
    if (accept) begin
      word_q[0] <= mem[req_addr];
    end
    sel_q[0] <= req_sel;
    tag_q[0] <= bus.req_tag;
    for (int i = 1; i < int'(RAM_LATENCY); i++) begin
      word_q[i] <= word_q[i-1];
      sel_q[i]  <= sel_q[i-1];
      tag_q[i]  <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < int'(RAM_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: slot mux, hit/miss, push/drop decisions
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0]    slot_bits;
  logic                 s_valid, s_hit, s_miss;
  logic [IDX_WIDTH-1:0] s_idx;
  logic                 push, drop, pop;

  assign slot_bits = word_q[LAST][int'(sel_q[LAST])*SLOT_W +: SLOT_W];
  assign s_valid   = vld_q[LAST];
  assign s_hit     = slot_bits[SLOT_W-1];
  assign s_idx     = s_hit ? slot_bits[IDX_WIDTH-1:0] : '0;
  assign s_miss    = s_valid && !s_hit;
  assign push      = s_valid && (s_hit || !DROP_MISS);
  assign drop      = s_miss && DROP_MISS;

  // ---------------------------------------------------------------------------
  // Output FIFO (credits guarantee it never overflows)
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] head;
  logic               not_empty;

  localparam logic [PTR_W:0] PtrOne = (PTR_W + 1)'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= {s_hit, s_idx, tag_q[LAST]};
    end
  end

  assign not_empty = (wr_ptr_q != rd_ptr_q);
  assign pop       = not_empty && bus.rsp_ready;
  assign head      = fifo_q[rd_ptr_q[PTR_W-1:0]];

  // Gate with not_empty so outputs read 0 while empty (storage is not reset).
  assign bus.rsp_valid = not_empty;
  assign bus.rsp_hit   = not_empty & head[ENTRY_W-1];
  assign bus.rsp_idx   = not_empty ? head[TAG_WIDTH +: IDX_WIDTH] : '0;
  assign bus.rsp_tag   = not_empty ? head[TAG_WIDTH-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Credits and miss counter
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_d = inflight_q;
    if (accept) inflight_d = inflight_d + CntOne;
    if (pop)    inflight_d = inflight_d - CntOne;
    if (drop)   inflight_d = inflight_d - CntOne;
  end

  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      inflight_q <= inflight_d;
      if (s_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign miss_cnt = miss_cnt_q;
  assign inflight = inflight_q;

endmodule

// File: tb/tb_tts_sym_xlate.sv
// Directed bench for tts_sym_xlate. Two instances share the host-write port:
//   u_dut_a : defaults (RAM_LATENCY=1, FIFO_DEPTH=4, DROP_MISS=0)
//   u_dut_b : RAM_LATENCY=3, FIFO_DEPTH=4, DROP_MISS=1
module tb_tts_sym_xlate;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] miss_a, miss_b;
  logic [2:0]  infl_a, infl_b;
  int          checks = 0;
  int          errors = 0;

  tts_sym_xlate_if ifa ();
  tts_sym_xlate_if ifb ();

  tts_sym_xlate u_dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (ifa),
    .miss_cnt (miss_a),
    .inflight (infl_a)
  );

  tts_sym_xlate #(
    .RAM_LATENCY (3),
    .FIFO_DEPTH  (4),
    .DROP_MISS   (1'b1)
  ) u_dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (ifb),
    .miss_cnt (miss_b),
    .inflight (infl_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Host write goes to both instances so they hold identical tables.
  task automatic hw_write(input logic [13:0] addr, input logic [1:0] slot,
                          input logic vld, input logic [13:0] idx);
    ifa.hw_en = 1'b1; ifa.hw_addr = addr; ifa.hw_slot = slot;
    ifa.hw_vld = vld; ifa.hw_idx = idx;
    ifb.hw_en = 1'b1; ifb.hw_addr = addr; ifb.hw_slot = slot;
    ifb.hw_vld = vld; ifb.hw_idx = idx;
    tick();
    ifa.hw_en = 1'b0;
    ifb.hw_en = 1'b0;
  endtask

  task automatic drive_req(input bit on_b, input logic v, input logic [15:0] sym,
                           input logic [7:0] tag);
    if (on_b) begin
      ifb.req_valid = v; ifb.req_sym = sym; ifb.req_tag = tag;
    end else begin
      ifa.req_valid = v; ifa.req_sym = sym; ifa.req_tag = tag;
    end
  endtask

  task automatic get_rsp(input bit on_b, output logic rv, output logic [13:0] idx,
                         output logic hit, output logic [7:0] tag, output logic rr);
    rv  = on_b ? ifb.rsp_valid : ifa.rsp_valid;
    idx = on_b ? ifb.rsp_idx   : ifa.rsp_idx;
    hit = on_b ? ifb.rsp_hit   : ifa.rsp_hit;
    tag = on_b ? ifb.rsp_tag   : ifa.rsp_tag;
    rr  = on_b ? ifb.req_ready : ifa.req_ready;
  endtask

  // Single lookup with rsp_ready high; lat counts cycles from accept to rsp_valid.
  task automatic lookup(input bit on_b, input logic [15:0] sym, input logic [7:0] tag,
                        input logic [13:0] exp_idx, input logic exp_hit, input int exp_lat);
    int          lat;
    logic        rv, hit, rr;
    logic [13:0] idx;
    logic [7:0]  tg;
    drive_req(on_b, 1'b1, sym, tag);
    get_rsp(on_b, rv, idx, hit, tg, rr);
    check_eq(on_b ? "b_req_ready" : "a_req_ready", rr, 1'b1);
    tick();
    drive_req(on_b, 1'b0, sym, tag);
    lat = 1;
    get_rsp(on_b, rv, idx, hit, tg, rr);
    while (!rv && lat < 20) begin
      tick();
      lat++;
      get_rsp(on_b, rv, idx, hit, tg, rr);
    end
    check_eq(on_b ? "b_latency" : "a_latency", lat, exp_lat);
    check_eq(on_b ? "b_idx" : "a_idx", idx, exp_idx);
    check_eq(on_b ? "b_hit" : "a_hit", hit, exp_hit);
    check_eq(on_b ? "b_tag" : "a_tag", tg, tag);
    tick();
  endtask

  task automatic count_rsp(input bit on_b, input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      if (on_b ? ifb.rsp_valid : ifa.rsp_valid) n++;
      tick();
    end
  endtask

  initial begin
    int          n;
    logic        rdy;
    logic [15:0] bp_sym [5];
    logic [13:0] bp_idx [4];

    bp_sym = '{16'h000C, 16'h000D, 16'h000E, 16'h000F, 16'h0042};
    bp_idx = '{14'h0001, 14'h3FFF, 14'h0003, 14'h0004};

    drive_req(1'b0, 1'b0, 16'h0, 8'h0);
    drive_req(1'b1, 1'b0, 16'h0, 8'h0);
    ifa.rsp_ready = 1'b1; ifb.rsp_ready = 1'b1;
    ifa.hw_en = 1'b0; ifa.hw_addr = '0; ifa.hw_slot = '0; ifa.hw_vld = 1'b0; ifa.hw_idx = '0;
    ifb.hw_en = 1'b0; ifb.hw_addr = '0; ifb.hw_slot = '0; ifb.hw_vld = 1'b0; ifb.hw_idx = '0;

    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state
    check_eq("rst_rsp_valid", ifa.rsp_valid, 1'b0);
    check_eq("rst_rsp_idx", ifa.rsp_idx, 14'h0);
    check_eq("rst_rsp_hit", ifa.rsp_hit, 1'b0);
    check_eq("rst_rsp_tag", ifa.rsp_tag, 8'h0);
    check_eq("rst_miss_cnt", miss_a, 32'h0);
    check_eq("rst_inflight", infl_a, 3'd0);
    check_eq("rst_req_ready", ifa.req_ready, 1'b1);
    check_eq("rst_b_rsp_valid", ifb.rsp_valid, 1'b0);

    // Basic hit: addr 0x10 slot 2 -> sym 0x0042
    hw_write(14'h10, 2'd2, 1'b1, 14'h1ABC);
    lookup(1'b0, 16'h0042, 8'h5A, 14'h1ABC, 1'b1, 2);
    check_eq("basic_miss_cnt", miss_a, 32'h0);
    check_eq("basic_inflight", infl_a, 3'd0);

    // Slot isolation in addr 3
    hw_write(14'h3, 2'd0, 1'b1, 14'h0001);
    hw_write(14'h3, 2'd1, 1'b1, 14'h0002);
    hw_write(14'h3, 2'd2, 1'b1, 14'h0003);
    hw_write(14'h3, 2'd3, 1'b1, 14'h0004);
    hw_write(14'h3, 2'd1, 1'b1, 14'h3FFF);
    for (int i = 0; i < 4; i++) begin
      lookup(1'b0, bp_sym[i], 8'(8'h20 + i), bp_idx[i], 1'b1, 2);
    end

    // Miss forwarded: stored idx is nonzero but must read back as 0
    hw_write(14'h5, 2'd1, 1'b0, 14'h1234);
    lookup(1'b0, 16'h0015, 8'h33, 14'h0, 1'b0, 2);
    check_eq("miss_cnt_a", miss_a, 32'd1);

    // Collision: write and lookup of the same word in the same cycle
    hw_write(14'h10, 2'd0, 1'b1, 14'h0111);
    ifa.hw_en = 1'b1; ifa.hw_addr = 14'h10; ifa.hw_slot = 2'd0;
    ifa.hw_vld = 1'b1; ifa.hw_idx = 14'h0222;
    ifb.hw_en = 1'b1; ifb.hw_addr = 14'h10; ifb.hw_slot = 2'd0;
    ifb.hw_vld = 1'b1; ifb.hw_idx = 14'h0222;
    drive_req(1'b0, 1'b1, 16'h0040, 8'h11);
    tick();
    ifa.hw_en = 1'b0; ifb.hw_en = 1'b0;
    drive_req(1'b0, 1'b1, 16'h0040, 8'h12);
    tick();
    drive_req(1'b0, 1'b0, 16'h0040, 8'h12);
    check_eq("coll_old_valid", ifa.rsp_valid, 1'b1);
    check_eq("coll_old_idx", ifa.rsp_idx, 14'h0111);
    check_eq("coll_old_tag", ifa.rsp_tag, 8'h11);
    tick();
    check_eq("coll_new_valid", ifa.rsp_valid, 1'b1);
    check_eq("coll_new_idx", ifa.rsp_idx, 14'h0222);
    check_eq("coll_new_tag", ifa.rsp_tag, 8'h12);
    tick();
    check_eq("coll_drained", ifa.rsp_valid, 1'b0);

    // Reset mid-stream: 3 requests held in flight, then 1-cycle reset
    ifa.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 1'b1, 16'h0042, 8'(8'h60 + i));
      tick();
    end
    drive_req(1'b0, 1'b0, 16'h0, 8'h0);
    check_eq("pre_rst_inflight", infl_a, 3'd3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("mid_rst_rsp_valid", ifa.rsp_valid, 1'b0);
    check_eq("mid_rst_inflight", infl_a, 3'd0);
    check_eq("mid_rst_miss_cnt", miss_a, 32'h0);
    check_eq("mid_rst_req_ready", ifa.req_ready, 1'b1);
    ifa.rsp_ready = 1'b1;
    count_rsp(1'b0, 6, n);
    check_eq("mid_rst_no_rsp", n, 0);
    lookup(1'b0, 16'h0042, 8'h71, 14'h1ABC, 1'b1, 2);
    lookup(1'b0, 16'h000D, 8'h72, 14'h3FFF, 1'b1, 2);

    // Instance B: dropped miss releases its credit, no response
    drive_req(1'b1, 1'b1, 16'h0015, 8'h44);
    tick();
    drive_req(1'b1, 1'b0, 16'h0, 8'h0);
    check_eq("drop_inflight_held", infl_b, 3'd1);
    count_rsp(1'b1, 8, n);
    check_eq("drop_no_rsp", n, 0);
    check_eq("drop_miss_cnt", miss_b, 32'd1);
    check_eq("drop_inflight_free", infl_b, 3'd0);

    // Instance B: latency RAM_LATENCY+1 = 4
    lookup(1'b1, 16'h0042, 8'h77, 14'h1ABC, 1'b1, 4);

    // Instance B: back-pressure, exactly FIFO_DEPTH accepts
    ifb.rsp_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      drive_req(1'b1, 1'b1, bp_sym[n], 8'(n + 1));
      rdy = ifb.req_ready;
      tick();
      if (rdy) n++;
    end
    drive_req(1'b1, 1'b0, 16'h0, 8'h0);
    check_eq("bp_accepts", n, 4);
    check_eq("bp_req_ready_low", ifb.req_ready, 1'b0);
    check_eq("bp_inflight_full", infl_b, 3'd4);
    for (int s = 0; s < 2; s++) begin
      check_eq("bp_stall_valid", ifb.rsp_valid, 1'b1);
      check_eq("bp_stall_idx", ifb.rsp_idx, 14'h0001);
      check_eq("bp_stall_tag", ifb.rsp_tag, 8'd1);
      tick();
    end
    ifb.rsp_ready = 1'b1;
    // First pop happens at the next edge; credit returns with it.
    check_eq("bp_ready_before_pop", ifb.req_ready, 1'b0);
    tick();
    check_eq("bp_ready_after_pop", ifb.req_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      check_eq("bp_order_valid", ifb.rsp_valid, 1'b1);
      check_eq("bp_order_idx", ifb.rsp_idx, bp_idx[i]);
      check_eq("bp_order_tag", ifb.rsp_tag, 8'(i + 1));
      tick();
    end
    check_eq("bp_drained", ifb.rsp_valid, 1'b0);
    check_eq("bp_inflight_zero", infl_b, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
